seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: operation request from the controller, held high until done is seen.
REQ-004 SHALL have port opcode, input, 3 bits: operation select, sampled with start.
REQ-005 SHALL have port a, input, 16 bits: operand A, sampled with start.
REQ-006 SHALL have port b, input, 16 bits: operand B, sampled with start.
REQ-007 SHALL have port result_low, output, 17 bits: primary result; bit 16 is carry/borrow.
REQ-008 SHALL have port result_high, output, 17 bits: secondary result (product high, remainder); bit 16 is the error flag.
REQ-009 SHALL have port done, output, 1 bit: result-valid pulse.

Function
REQ-010 SHALL decode opcode as: 000 ADD, 001 SUB, 010 MUL (unsigned), 011 DIV (unsigned), 100 AND, 101 OR, 110 XOR, 111 PASS (A).
REQ-011 SHALL implement states IDLE, EXEC, DONE, HOLD.
REQ-012 IDLE: on start=1, SHALL latch opcode, a and b, then go to EXEC; later input changes are ignored until the next acceptance.
REQ-013 EXEC, single-cycle ops (ADD, SUB, logic, PASS): SHALL register results at the first EXEC edge, then go to DONE.
REQ-014 EXEC, MUL/DIV: SHALL iterate exactly 16 cycles (shift-add / restoring), then go to DONE.
REQ-015 Latency, start accepted at edge 0: done SHALL be high after edge 2 for single-cycle ops and after edge 17 for MUL/DIV.
REQ-016 DONE: done=1 for exactly one cycle; next state SHALL be HOLD if start=1, else IDLE.
REQ-017 HOLD: SHALL wait for start=0, then go to IDLE; this prevents re-triggering on a start that is still high.
REQ-018 Results: SHALL stay stable from done until the next acceptance.
REQ-019 ADD: result_low = {carry, a+b}.
REQ-020 SUB: result_low = 17-bit a-b, with bit 16 = borrow.
REQ-021 ADD and SUB: result_high = 0.
REQ-022 MUL: result_low = {0, P[15:0]} and result_high = {0, P[31:16]}, where P = a*b.
REQ-023 DIV, b≠0: result_low = {0, a/b} and result_high = {0, a%b}.
REQ-024 DIV, b=0: result_low = {0, FFFF} and result_high = {1, a}.
REQ-025 Logic ops and PASS: result_low = {0, value}; result_high = 0.
REQ-026 start=1 while in EXEC, DONE or HOLD SHALL be ignored.

Reset
REQ-027 On reset=0, at any time including mid-iteration: state=IDLE, done=0, result_low=0, result_high=0, and iteration counter and latched operands cleared.
REQ-028 After reset is released, the first start SHALL be accepted normally.

Configuration
REQ-029 Macro ALU_DIV_EN defined: the iterative divider SHALL be compiled in and DIV SHALL behave per REQ-023/REQ-024.
REQ-030 Macro ALU_DIV_EN undefined: no divider logic; DIV SHALL complete as a single-cycle op with result_low=0 and result_high={1, 0000}.

Structure
REQ-031 Package alu_pkg SHALL hold: the opcode enum (3 bits), the state enum, WIDTH=16, RES_WIDTH=17 and ITER_COUNT=16.
REQ-032 The iterative MUL/DIV datapath SHALL be a sub-module alu_muldiv_core.
REQ-033 alu_muldiv_core SHALL have a go/busy/finish interface and a 5-bit counter.
REQ-034 seq_alu SHALL keep the FSM and the single-cycle ops.

Verification
REQ-035 ADD a=FFFF, b=0001 -> done 2 cycles after accept; result_low=1_0000, result_high=0.
REQ-036 SUB a=0003, b=0005 -> result_low=1_FFFE.
REQ-037 MUL a=FFFF, b=FFFF -> done after 17 cycles; result_low=0_0001, result_high=0_FFFE.
REQ-038 DIV a=0064, b=0007 -> result_low=0_000E, result_high=0_0002.
REQ-039 DIV a=1234, b=0 -> result_high=1_1234, result_low=0_FFFF.
REQ-040 DIV a=1234, b=0 with ALU_DIV_EN undefined -> result_low=0, result_high=1_0000.
REQ-041 Start held high 3 cycles after done -> exactly one done pulse, no second operation.
REQ-042 reset=0 at MUL iteration 8 -> done=0 and results=0 immediately.
REQ-043 After REQ-042, a new ADD -> completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and sizes for seq_alu; ALU_DIV_EN selects the iterative divider.
package alu_pkg;
  localparam int WIDTH      = 16;
  localparam int RES_WIDTH  = 17;
  localparam int ITER_COUNT = 16;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_PASS = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE,
    S_HOLD
  } state_e;

  function automatic logic is_iter(input opcode_e op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction
endpackage

// File: rtl/alu_muldiv_core.sv
// rtl/alu_muldiv_core.sv - 16-step shift-add multiplier; restoring divider only when ALU_DIV_EN is defined.
module alu_muldiv_core
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
`ifdef ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             finish,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   shifted;
`endif

  // hi holds partial product / remainder, lo holds multiplier / quotient bits
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
`ifdef ALU_DIV_EN
    div_d   = div_q;
    shifted = {hi_q, lo_q[WIDTH-1]};
`endif
    if (go) begin
      hi_d   = '0;
      lo_d   = b;
      opnd_d = a;
      cnt_d  = 5'(ITER_COUNT);
      busy_d = 1'b1;
`ifdef ALU_DIV_EN
      div_d  = is_div;
      if (is_div) begin
        lo_d   = a;
        opnd_d = b;
      end
`endif
    end else if (busy_q) begin
      cnt_d  = cnt_q - 5'd1;
      busy_d = (cnt_q != 5'd1);
      hi_d   = mul_sum[WIDTH:1];
      lo_d   = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
      if (div_q) begin
        if (shifted >= {1'b0, opnd_q}) begin
          hi_d = shifted[WIDTH-1:0] - opnd_q;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shifted[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
`ifdef ALU_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

  // Results are exported from the final step's next-state so the top can register them on that edge
  assign busy   = busy_q;
  assign finish = busy_q && (cnt_q == 5'd1);
  assign res_lo = lo_d;
  assign res_hi = hi_d;
endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential 16-bit ALU: control FSM and single-cycle ops; DIV is iterative only with ALU_DIV_EN.
module seq_alu
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           opcode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [RES_WIDTH-1:0] result_low,
  output logic [RES_WIDTH-1:0] result_high,
  output logic                 done
);
  state_e               state_q, state_d;
  opcode_e              op_q, op_d, op_in;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [RES_WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic                 done_q, done_d;
  logic [RES_WIDTH-1:0] sum, diff;
  logic                 core_go, core_busy, core_finish;
  logic [WIDTH-1:0]     core_lo, core_hi;

  assign op_in = opcode_e'(opcode);

  alu_muldiv_core u_core (
    .clk    (clk),
    .reset  (reset),
    .go     (core_go),
`ifdef ALU_DIV_EN
    .is_div (op_in == OP_DIV),
`endif
    .a      (a),
    .b      (b),
    .busy   (core_busy),
    .finish (core_finish),
    .res_lo (core_lo),
    .res_hi (core_hi)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    done_d   = 1'b0;
    core_go  = 1'b0;
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_in;
          a_d     = a;
          b_d     = b;
          state_d = S_EXEC;
          core_go = is_iter(op_in) && !core_busy;
        end
      end
      S_EXEC: begin
        if (is_iter(op_q)) begin
          if (core_finish) begin
            state_d  = S_DONE;
            res_lo_d = {1'b0, core_lo};
            res_hi_d = {1'b0, core_hi};
            if (op_q == OP_DIV && b_q == '0) begin
              res_lo_d = {1'b0, {WIDTH{1'b1}}};
              res_hi_d = {1'b1, a_q};
            end
          end
        end else begin
          state_d  = S_DONE;
          res_hi_d = '0;
          case (op_q)
            OP_ADD:  res_lo_d = sum;
            OP_SUB:  res_lo_d = diff;
            OP_AND:  res_lo_d = {1'b0, a_q & b_q};
            OP_OR:   res_lo_d = {1'b0, a_q | b_q};
            OP_XOR:  res_lo_d = {1'b0, a_q ^ b_q};
            OP_PASS: res_lo_d = {1'b0, a_q};
            OP_DIV: begin
              res_lo_d = '0;
              res_hi_d = {1'b1, {WIDTH{1'b0}}};
            end
            default: res_lo_d = '0;
          endcase
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = start ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      done_q   <= done_d;
    end
  end

  assign result_low  = res_lo_q;
  assign result_high = res_hi_q;
  assign done        = done_q;
endmodule
